// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: matrix geometry, FSM encoding
// and the lowest-set-bit helper used to pick one key out of a group.
package keypad_scanner_pkg;

  localparam int KP_COLS   = 4;
  localparam int KP_ROWS   = 4;
  localparam int KP_MAP_W  = KP_COLS * KP_ROWS;
  localparam int KP_CODE_W = 4;
  localparam int KP_COL_W  = $clog2(KP_COLS);

  typedef enum logic [0:0] {
    KP_ST_SCAN = 1'b0,
    KP_ST_EVAL = 1'b1
  } kp_state_e;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [KP_CODE_W-1:0] kp_lowest_set(input logic [KP_MAP_W-1:0] bits);
    logic [KP_CODE_W-1:0] idx;
    idx = {KP_CODE_W{1'b0}};
    for (int i = KP_MAP_W - 1; i >= 0; i--) begin
      idx = bits[i] ? KP_CODE_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces one full-matrix snapshot per scan and flags the lowest newly
// pressed key whenever the debounced map is refreshed.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 eval,
  input  logic [KP_MAP_W-1:0]  raw,
  output logic [KP_MAP_W-1:0]  key_map,
  output logic                 key_event,
  output logic [KP_CODE_W-1:0] event_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [KP_MAP_W-1:0] last_raw_r;
  logic [KP_MAP_W-1:0] new_keys_s;
  logic [CNT_W-1:0]    stable_cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                update_s;

  // The map refreshes on every EVAL where the counter is (or lands) at its
  // saturation value, so DEBOUNCE_SCANS = 1 follows the raw scan directly.
  always_comb begin
    if (raw != last_raw_r) begin
      cnt_nxt_s = CNT_ONE;
    end else if (stable_cnt_r < CNT_MAX) begin
      cnt_nxt_s = stable_cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = stable_cnt_r;
    end
    update_s   = eval && (cnt_nxt_s == CNT_MAX);
    new_keys_s = raw & ~key_map;
    key_event  = update_s && (|new_keys_s);
    event_code = kp_lowest_set(new_keys_s);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_raw_r   <= {KP_MAP_W{1'b0}};
      stable_cnt_r <= {CNT_W{1'b0}};
      key_map      <= {KP_MAP_W{1'b0}};
    end else if (eval) begin
      last_raw_r   <= raw;
      stable_cnt_r <= cnt_nxt_s;
      if (update_s) begin
        key_map <= raw;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep FSM, row synchronizer, debounced
// key map and a single-entry key event slot with valid/ready handshake.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [KP_ROWS-1:0]   keypad_row,
  output logic [KP_COLS-1:0]   keypad_col,
  output logic                 key_valid,
  output logic [KP_CODE_W-1:0] key_code,
  input  logic                 key_ready,
  output logic [KP_MAP_W-1:0]  key_map,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [KP_COL_W-1:0] COL_LAST = KP_COL_W'(KP_COLS - 1);
  localparam logic [KP_COL_W-1:0] COL_ONE  = KP_COL_W'(1);

  kp_state_e            state_r, state_nxt_s;
  logic [KP_COL_W-1:0]  col_idx_r, col_nxt_s;
  logic [DIV_W-1:0]     div_r, div_nxt_s;
  logic [KP_ROWS-1:0]   row_meta_r, row_sync_r;
  logic [KP_MAP_W-1:0]  raw_r;
  logic                 sample_s, eval_s;
  logic [KP_COLS-1:0]   col_drive_s;
  logic                 evt_s;
  logic [KP_CODE_W-1:0] evt_code_s;
  logic                 xfer_s, load_s, drop_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= KP_ST_SCAN;
      col_idx_r <= {KP_COL_W{1'b0}};
      div_r     <= {DIV_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      col_idx_r <= col_nxt_s;
      div_r     <= div_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_idx_r;
    div_nxt_s   = div_r;
    case (state_r)
      KP_ST_SCAN: begin
        if (div_r == DIV_LAST) begin
          div_nxt_s   = {DIV_W{1'b0}};
          col_nxt_s   = col_idx_r + COL_ONE;
          state_nxt_s = (col_idx_r == COL_LAST) ? KP_ST_EVAL : KP_ST_SCAN;
        end else begin
          div_nxt_s = div_r + DIV_ONE;
        end
      end
      KP_ST_EVAL: begin
        state_nxt_s = KP_ST_SCAN;
        col_nxt_s   = {KP_COL_W{1'b0}};
        div_nxt_s   = {DIV_W{1'b0}};
      end
      default: begin
        state_nxt_s = KP_ST_SCAN;
        col_nxt_s   = {KP_COL_W{1'b0}};
        div_nxt_s   = {DIV_W{1'b0}};
      end
    endcase
  end

  // Column drive is computed from the next state so the registered pin
  // matches the column being scanned in the same cycle.
  always_comb begin
    sample_s    = (state_r == KP_ST_SCAN) && (div_r == DIV_LAST);
    eval_s      = (state_r == KP_ST_EVAL);
    if (state_nxt_s == KP_ST_SCAN) begin
      col_drive_s = ~(4'b0001 << col_nxt_s);
    end else begin
      col_drive_s = 4'b1111;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_meta_r <= {KP_ROWS{1'b0}};
      row_sync_r <= {KP_ROWS{1'b0}};
      raw_r      <= {KP_MAP_W{1'b0}};
      keypad_col <= 4'b1111;
    end else begin
      row_meta_r <= keypad_row;
      row_sync_r <= row_meta_r;
      keypad_col <= col_drive_s;
      if (sample_s) begin
        raw_r[{col_idx_r, 2'b00} +: KP_ROWS] <= ~row_sync_r;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rstn       (rstn),
    .eval       (eval_s),
    .raw        (raw_r),
    .key_map    (key_map),
    .key_event  (evt_s),
    .event_code (evt_code_s)
  );

  always_comb begin
    xfer_s = key_valid && key_ready;
    load_s = evt_s && (!key_valid || xfer_s);
    drop_s = evt_s && key_valid && !xfer_s;
  end

  // A drop in the same cycle as overflow_clr keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_valid <= 1'b0;
      key_code  <= {KP_CODE_W{1'b0}};
      overflow  <= 1'b0;
    end else begin
      if (load_s) begin
        key_valid <= 1'b1;
        key_code  <= evt_code_s;
      end else if (xfer_s) begin
        key_valid <= 1'b0;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a cycle-counting behavioural model
// of the scan/debounce/handshake rules plus directed scenarios.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int PERIOD   = 4 * SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  keypad_row;
  logic [3:0]  keypad_col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [15:0] key_map;
  logic        overflow;
  logic        overflow_clr;

  logic [15:0] pressed;
  logic        armed;
  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  int          xfers = 0;
  logic [3:0]  last_code = 4'd0;
  logic [15:0] map_or = 16'h0000;

  typedef struct packed {
    int          k;
    logic [15:0] raw;
    logic [15:0] last;
    logic [15:0] map;
    logic [15:0] h0;
    logic [15:0] h1;
    int          cnt;
    logic        valid;
    logic [3:0]  code;
    logic        ovf;
  } model_t;

  model_t m;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .keypad_row   (keypad_row),
    .keypad_col   (keypad_col),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .key_map      (key_map),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Passive matrix: a pressed key shorts its row to its column when driven low.
  function automatic logic [3:0] rows_of(input logic [15:0] pr, input logic [3:0] col);
    logic [3:0] r;
    r = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        if (pr[c*4+rr] && !col[c]) r[rr] = 1'b0;
    return r;
  endfunction

  assign keypad_row = rows_of(pressed, keypad_col);

  // Expected column drive after k clock edges since reset release.
  function automatic logic [3:0] col_exp(input int k);
    int q;
    logic [3:0] one;
    one = 4'b0001;
    q = k % PERIOD;
    if (k == 0) return 4'b1111;
    if (q < 4 * SCAN_DIV) return ~(one << (q / SCAN_DIV));
    return 4'b1111;
  endfunction

  // One clock edge of the specified behaviour; pins reach the scan two edges late.
  function automatic model_t step(input model_t s, input logic [15:0] pr,
                                  input logic rdy, input logic clr);
    model_t n;
    int q, c, cnt_n;
    logic ev, xfer, set_ovf;
    logic [15:0] nw;
    logic [3:0] code;
    n = s;
    q = s.k % PERIOD;
    ev = 1'b0;
    code = 4'd0;
    if (q < 4 * SCAN_DIV && (q % SCAN_DIV) == SCAN_DIV - 1) begin
      c = q / SCAN_DIV;
      n.raw[c*4 +: 4] = s.h1[c*4 +: 4];
    end
    if (q == 4 * SCAN_DIV) begin
      if (s.raw != s.last) cnt_n = 1;
      else if (s.cnt < DEB) cnt_n = s.cnt + 1;
      else cnt_n = s.cnt;
      n.last = s.raw;
      n.cnt = cnt_n;
      if (cnt_n == DEB) begin
        nw = s.raw & ~s.map;
        n.map = s.raw;
        for (int i = 15; i >= 0; i--) if (nw[i]) code = 4'(i);
        ev = (nw != 16'h0000);
      end
    end
    xfer = s.valid && rdy;
    set_ovf = ev && s.valid && !xfer;
    if (ev && !set_ovf) begin
      n.valid = 1'b1;
      n.code = code;
    end else if (xfer) begin
      n.valid = 1'b0;
    end
    n.ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : s.ovf);
    n.h1 = s.h0;
    n.h0 = pr;
    n.k = s.k + 1;
    return n;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_k(input int n);
    int g;
    g = 0;
    while (m.k < n && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (m.k != n) begin
      checks++;
      errors++;
      $display("FAIL wait_k: reached cycle %0d, wanted %0d", m.k, n);
    end
  endtask

  task automatic do_reset(input logic [15:0] pr, input logic rdy);
    @(negedge clk);
    #2 rstn = 1'b0;
    pressed = pr;
    key_ready = rdy;
    overflow_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    m = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) m = '0;
      else m = step(m, pressed, key_ready, overflow_clr);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rstn) begin
        xfers = 0;
      end else if (key_valid && key_ready) begin
        xfers++;
        last_code = key_code;
      end
    end
  end

  initial begin
    wait (armed);
    forever begin
      @(negedge clk);
      chk("keypad_col", 16'(keypad_col), 16'(col_exp(m.k)));
      chk("key_valid", 16'(key_valid), 16'(m.valid));
      chk("key_code", 16'(key_code), 16'(m.code));
      chk("key_map", key_map, m.map);
      chk("overflow", 16'(overflow), 16'(m.ovf));
      if (!rstn) begin
        vcount = 0;
        map_or = 16'h0000;
      end else begin
        if (key_valid) vcount++;
        map_or = map_or | key_map;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pressed = 16'h0000;
    key_ready = 1'b0;
    overflow_clr = 1'b0;
    armed = 1'b0;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    chk("rst_col", 16'(keypad_col), 16'h000f);
    chk("rst_valid", 16'(key_valid), 16'h0000);
    chk("rst_map", key_map, 16'h0000);
    chk("rst_ovf", 16'(overflow), 16'h0000);

    // Single press held, consumer always ready.
    do_reset(16'h0020, 1'b1);
    @(negedge clk);
    chk("first_col", 16'(keypad_col), 16'h000e);
    wait_k(50);
    chk("t1_map_early", key_map, 16'h0000);
    wait_k(51);
    chk("t1_valid", 16'(key_valid), 16'h0001);
    chk("t1_code", 16'(key_code), 16'h0005);
    chk("t1_map", key_map, 16'h0020);
    pressed = 16'h0000;
    wait_k(52);
    chk("t1_valid_drop", 16'(key_valid), 16'h0000);
    chk("t1_xfer_code", 16'(last_code), 16'h0005);
    wait_k(101);
    chk("t1_map_held", key_map, 16'h0020);
    wait_k(102);
    chk("t1_map_release", key_map, 16'h0000);
    wait_k(120);
    chk("t1_xfers", 16'(xfers), 16'h0001);
    chk("t1_vcycles", 16'(vcount), 16'h0001);

    // Bounce: key 5 toggles every scan for 10 scans, then stays released.
    do_reset(16'h0020, 1'b1);
    for (int s = 1; s < 10; s++) begin
      wait_k(PERIOD * s);
      pressed = (s % 2 == 0) ? 16'h0020 : 16'h0000;
    end
    wait_k(PERIOD * 13);
    chk("t2_vcycles", 16'(vcount), 16'h0000);
    chk("t2_map_or", map_or, 16'h0000);
    chk("t2_xfers", 16'(xfers), 16'h0000);

    // Keys 2 and 9 pressed in the same scan.
    do_reset(16'h0204, 1'b0);
    wait_k(51);
    chk("t3_valid", 16'(key_valid), 16'h0001);
    chk("t3_code", 16'(key_code), 16'h0002);
    chk("t3_map", key_map, 16'h0204);
    chk("t3_ovf", 16'(overflow), 16'h0000);
    wait_k(52);
    chk("t3_hold", 16'(key_code), 16'h0002);

    // Backpressure: key 3 pending, key 12 arrives and is dropped.
    do_reset(16'h0008, 1'b0);
    wait_k(51);
    chk("t4_code3", 16'(key_code), 16'h0003);
    pressed = 16'h0000;
    wait_k(102);
    chk("t4_map_rel", key_map, 16'h0000);
    chk("t4_still_valid", 16'(key_valid), 16'h0001);
    pressed = 16'h1000;
    wait_k(152);
    chk("t4_ovf_before", 16'(overflow), 16'h0000);
    wait_k(153);
    chk("t4_ovf", 16'(overflow), 16'h0001);
    chk("t4_code_kept", 16'(key_code), 16'h0003);
    chk("t4_map12", key_map, 16'h1000);
    key_ready = 1'b1;
    wait_k(154);
    key_ready = 1'b0;
    chk("t4_valid_drop", 16'(key_valid), 16'h0000);
    chk("t4_xfer_code", 16'(last_code), 16'h0003);
    chk("t4_ovf_sticky", 16'(overflow), 16'h0001);
    overflow_clr = 1'b1;
    wait_k(155);
    overflow_clr = 1'b0;
    chk("t4_ovf_clr", 16'(overflow), 16'h0000);

    // Transfer of key 3 lines up with the EVAL that raises key 7.
    do_reset(16'h0008, 1'b0);
    wait_k(51);
    pressed = 16'h0088;
    wait_k(101);
    key_ready = 1'b1;
    wait_k(102);
    key_ready = 1'b0;
    chk("t5_valid", 16'(key_valid), 16'h0001);
    chk("t5_code", 16'(key_code), 16'h0007);
    chk("t5_ovf", 16'(overflow), 16'h0000);
    chk("t5_xfers", 16'(xfers), 16'h0001);
    chk("t5_xfer_code", 16'(last_code), 16'h0003);
    chk("t5_map", key_map, 16'h0088);

    // Asynchronous reset during column 2 with an event pending.
    do_reset(16'h0020, 1'b0);
    wait_k(51);
    chk("t6_pending", 16'(key_valid), 16'h0001);
    wait_k(60);
    chk("t6_col2", 16'(keypad_col), 16'h000b);
    #2 rstn = 1'b0;
    #1;
    chk("t6_col", 16'(keypad_col), 16'h000f);
    chk("t6_valid", 16'(key_valid), 16'h0000);
    chk("t6_map", key_map, 16'h0000);
    chk("t6_code", 16'(key_code), 16'h0000);
    pressed = 16'h0000;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_restart_col", 16'(keypad_col), 16'h000e);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
